// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: owner encoding and the default burst limit, imported by the arbiter files.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } owner_e;

  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_reg.sv
// rtl/mem_port_arbiter_reg.sv - plain clear-on-reset register
// Purpose: WIDTH-bit register, loads i_d every rising edge, clears to 0 on rst.
// Ports:
//   clk  in          rising-edge clock
//   rst  in          synchronous active-high reset
//   i_d  in  [WIDTH] next value
//   o_q  out [WIDTH] registered value
module mem_port_arbiter_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port memory arbiter with lock and burst limit
// Purpose: shares one memory port between the core (m0) and the DMA/loader (m1).
//   Round-robin on ties, lock keeps the owner, a burst counter bounds a locked run.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mN_req/lock/addr/wr_data/wr_ena  requester N inputs (N = 0, 1)
//   mN_gnt                       access of requester N issued this cycle
//   mN_rd_valid                  read data for requester N valid this cycle
//   rd_data                      mem_rd_data passed through to both requesters
//   mem_addr/mem_wr_data/mem_wr_ena  memory command outputs
//   mem_rd_data                  memory read data, one cycle after the address
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic        m0_wr_ena,
  output logic        m0_gnt,
  output logic        m0_rd_valid,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic        m1_wr_ena,
  output logic        m1_gnt,
  output logic        m1_rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  localparam int CW = $clog2(MAX_BURST + 1);

  owner_e        r_owner;
  owner_e        w_next_owner;
  logic [CW-1:0] r_burst;
  logic [CW-1:0] w_burst_next;
  logic          r_locked;    // owner had req & lock in its last granted cycle
  logic          r_last_m1;   // most recent grant went to m1; reset 1 so m0 wins the first tie
  logic          w_owner_req;
  logic          w_other_req;
  logic          w_burst_full;
  logic [1:0]    w_tag_d;     // {read pending, pending owner is m1}
  logic [1:0]    w_tag_q;

  always_comb begin
    w_owner_req = 1'b0;
    w_other_req = 1'b0;
    case (r_owner)
      OWN_M0: begin w_owner_req = m0_req; w_other_req = m1_req; end
      OWN_M1: begin w_owner_req = m1_req; w_other_req = m0_req; end
      default: ;
    endcase
    w_burst_full = (r_burst >= CW'(MAX_BURST));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= IDLE;
      r_burst   <= '0;
      r_locked  <= 1'b0;
      r_last_m1 <= 1'b1;
    end else begin
      r_owner  <= w_next_owner;
      r_burst  <= w_burst_next;
      r_locked <= ((w_next_owner == OWN_M0) && m0_lock) ||
                  ((w_next_owner == OWN_M1) && m1_lock);
      if (w_next_owner != IDLE) r_last_m1 <= (w_next_owner == OWN_M1);
    end
  end

  // Next-state: the next owner is this cycle's grant
  always_comb begin
    w_next_owner = IDLE;
    if (rst) begin
      w_next_owner = IDLE;
    end else if (r_locked && w_owner_req) begin
      // A locked run yields only once the burst limit is hit and the other side waits
      if (w_burst_full && w_other_req)
        w_next_owner = (r_owner == OWN_M0) ? OWN_M1 : OWN_M0;
      else
        w_next_owner = r_owner;
    end else if (m0_req && m1_req) begin
      w_next_owner = r_last_m1 ? OWN_M0 : OWN_M1;
    end else if (m0_req) begin
      w_next_owner = OWN_M0;
    end else if (m1_req) begin
      w_next_owner = OWN_M1;
    end

    w_burst_next = '0;
    if (w_next_owner == IDLE)          w_burst_next = '0;
    else if (w_next_owner == r_owner)  w_burst_next = w_burst_full ? r_burst : r_burst + CW'(1);
    else                               w_burst_next = CW'(1);
  end

  // Outputs
  always_comb begin
    m0_gnt      = (w_next_owner == OWN_M0);
    m1_gnt      = (w_next_owner == OWN_M1);
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    case (w_next_owner)
      OWN_M0: begin mem_addr = m0_addr; mem_wr_data = m0_wr_data; mem_wr_ena = m0_wr_ena; end
      OWN_M1: begin mem_addr = m1_addr; mem_wr_data = m1_wr_data; mem_wr_ena = m1_wr_ena; end
      default: ;
    endcase
    w_tag_d = {(m0_gnt || m1_gnt) && !mem_wr_ena, m1_gnt};
    // A tag captured just before reset must not leak out while rst is high
    m0_rd_valid = !rst && w_tag_q[1] && !w_tag_q[0];
    m1_rd_valid = !rst && w_tag_q[1] &&  w_tag_q[0];
    rd_data     = mem_rd_data;
  end

  mem_port_arbiter_reg #(.WIDTH(2)) u_rd_tag (
    .clk (clk),
    .rst (rst),
    .i_d (w_tag_d),
    .o_q (w_tag_q)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MB = 4;
  localparam logic [31:0] RD0 = 32'hAAAA_0001;
  localparam logic [31:0] RD1 = 32'h5555_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m0_wr_ena, m0_gnt, m0_rd_valid;
  logic [31:0] m0_addr, m0_wr_data;
  logic        m1_req, m1_lock, m1_wr_ena, m1_gnt, m1_rd_valid;
  logic [31:0] m1_addr, m1_wr_data;
  logic [31:0] rd_data, mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr_ena;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_wr_ena(m0_wr_ena), .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_wr_ena(m1_wr_ena), .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data)
  );

  function automatic logic [31:0] init_word(input logic [5:0] idx);
    return 32'hC0DE_0000 | {26'd0, idx};
  endfunction

  // Memory environment: one-cycle read latency, written from the DUT's port
  logic [31:0] env_mem [64];
  bit          env_wr  [64];
  always @(posedge clk) begin
    if (mem_wr_ena) begin
      env_mem[mem_addr[7:2]] = mem_wr_data;
      env_wr[mem_addr[7:2]]  = 1'b1;
    end else begin
      mem_rd_data <= env_wr[mem_addr[7:2]] ? env_mem[mem_addr[7:2]] : init_word(mem_addr[7:2]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q0, input logic l0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic l1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst = r;
    m0_req = q0; m0_lock = l0; m0_wr_ena = w0; m0_addr = a0; m0_wr_data = d0;
    m1_req = q1; m1_lock = l1; m1_wr_ena = w1; m1_addr = a1; m1_wr_data = d1;
    #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        r;
    logic        q0, l0, w0;
    logic [31:0] a0, d0;
    logic        q1, l1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  ef;     // {gnt0, gnt1, rd_valid0, rd_valid1}
    logic [31:0] eaddr;
    logic        ewe;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r,
                     input logic q0, input logic l0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic q1, input logic l1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic [3:0] ef, input logic [31:0] eaddr, input logic ewe, input logic [31:0] erd);
    vec_t v;
    v.r = r; v.q0 = q0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ef = ef; v.eaddr = eaddr; v.ewe = ewe; v.erd = erd;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  int          m_last, m_owner, m_burst, m_pw;
  bit          m_lockon, m_pv;
  logic [5:0]  m_pidx;
  logic [31:0] ref_mem [64];
  bit          ref_wr  [64];

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_burst = 0; m_lockon = 0; m_pv = 0; m_pw = 0; m_pidx = '0;
  endtask

  task automatic model_step(input int cyc);
    bit          req[2], lk[2], we[2];
    logic [31:0] ad[2], wd[2];
    int          g;
    logic [3:0]  ef;
    logic [31:0] eaddr, ewd;
    logic        ewe;
    req[0] = m0_req; lk[0] = m0_lock; we[0] = m0_wr_ena; ad[0] = m0_addr; wd[0] = m0_wr_data;
    req[1] = m1_req; lk[1] = m1_lock; we[1] = m1_wr_ena; ad[1] = m1_addr; wd[1] = m1_wr_data;
    g = -1;
    if (!rst) begin
      if (m_lockon && req[m_owner])
        g = (m_burst >= MB && req[1 - m_owner]) ? 1 - m_owner : m_owner;
      else if (req[0] && req[1]) g = 1 - m_last;
      else if (req[0])           g = 0;
      else if (req[1])           g = 1;
    end
    ef    = {g == 0, g == 1, !rst && m_pv && m_pw == 0, !rst && m_pv && m_pw == 1};
    eaddr = (g >= 0) ? ad[g] : 32'd0;
    ewd   = (g >= 0) ? wd[g] : 32'd0;
    ewe   = (g >= 0) ? we[g] : 1'b0;
    chk($sformatf("rnd%0d flags", cyc), {28'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid}, {28'd0, ef});
    chk($sformatf("rnd%0d addr", cyc), mem_addr, eaddr);
    chk($sformatf("rnd%0d wdata", cyc), mem_wr_data, ewd);
    chk($sformatf("rnd%0d we", cyc), {31'd0, mem_wr_ena}, {31'd0, ewe});
    if (ef[1] || ef[0])
      chk($sformatf("rnd%0d rd_data", cyc), rd_data, ref_wr[m_pidx] ? ref_mem[m_pidx] : init_word(m_pidx));
    if (rst) begin
      model_reset();
    end else begin
      m_pv = (g >= 0) && !we[g];
      if (g >= 0) begin
        if (we[g]) begin ref_mem[ad[g][7:2]] = wd[g]; ref_wr[ad[g][7:2]] = 1'b1; end
        m_pidx   = ad[g][7:2];
        m_pw     = g;
        m_burst  = (g == m_owner) ? m_burst + 1 : 1;
        m_last   = g;
        m_lockon = lk[g];
      end else begin
        m_burst  = 0;
        m_lockon = 0;
      end
      m_owner = g;
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] ewd;

    drive(1, 0,0,0,0,0, 0,0,0,0,0);
    chk("reset flags", {28'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid}, 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    chk("reset we", {31'd0, mem_wr_ena}, 32'd0);
    drive(1, 0,0,0,0,0, 0,0,0,0,0);

    //   r  q0 l0 w0 a0     d0            q1 l1 w1 a1     d1    flags     addr   we erd
    add(0, 1,0,0,'h10,RD0,              0,0,0,'h00,RD1, 4'b1000, 'h10, 0, 0);
    add(0, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0010, 'h00, 0, init_word(4));
    add(1, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0000, 'h00, 0, 0);
    add(0, 1,0,0,'h04,RD0,              1,0,0,'h08,RD1, 4'b1000, 'h04, 0, 0);
    add(0, 1,0,0,'h0C,RD0,              1,0,0,'h08,RD1, 4'b0110, 'h08, 0, init_word(1));
    add(0, 1,0,0,'h0C,RD0,              1,0,0,'h14,RD1, 4'b1001, 'h0C, 0, init_word(2));
    add(0, 1,0,0,'h18,RD0,              1,0,0,'h14,RD1, 4'b0110, 'h14, 0, init_word(3));
    add(0, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0001, 'h00, 0, init_word(5));
    add(0, 1,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b1000, 'h00, 0, 0);
    add(0, 1,0,0,'h00,RD0,              1,1,0,'h1C,RD1, 4'b0110, 'h1C, 0, init_word(0));
    add(0, 1,0,0,'h00,RD0,              1,1,0,'h1C,RD1, 4'b0101, 'h1C, 0, init_word(7));
    add(0, 1,0,0,'h00,RD0,              1,1,0,'h1C,RD1, 4'b0101, 'h1C, 0, init_word(7));
    add(0, 1,0,0,'h00,RD0,              1,1,0,'h1C,RD1, 4'b0101, 'h1C, 0, init_word(7));
    add(0, 1,0,0,'h00,RD0,              1,1,0,'h1C,RD1, 4'b1001, 'h00, 0, init_word(7));
    add(0, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0010, 'h00, 0, init_word(0));
    add(0, 1,0,1,'h20,32'hDEADBEEF,     0,0,0,'h00,RD1, 4'b1000, 'h20, 1, 0);
    add(0, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0000, 'h00, 0, 0);
    add(0, 0,0,0,'h00,RD0,              1,0,0,'h20,RD1, 4'b0100, 'h20, 0, 0);
    add(0, 0,0,0,'h00,RD0,              0,0,0,'h00,RD1, 4'b0001, 'h00, 0, 32'hDEADBEEF);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.r, v.q0, v.l0, v.w0, v.a0, v.d0, v.q1, v.l1, v.w1, v.a1, v.d1);
      ewd = v.ef[3] ? v.d0 : (v.ef[2] ? v.d1 : 32'd0);
      chk($sformatf("tbl%0d flags", i), {28'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid}, {28'd0, v.ef});
      chk($sformatf("tbl%0d addr", i), mem_addr, v.eaddr);
      chk($sformatf("tbl%0d wdata", i), mem_wr_data, ewd);
      chk($sformatf("tbl%0d we", i), {31'd0, mem_wr_ena}, {31'd0, v.ewe});
      if (v.ef[1] || v.ef[0]) chk($sformatf("tbl%0d rd_data", i), rd_data, v.erd);
    end

    // Reset arriving while a read is outstanding and while a new read is requested
    drive(0, 1,0,0,'h10,RD0, 0,0,0,0,RD1);
    chk("pre_rst gnt", {31'd0, m0_gnt}, 32'd1);
    drive(1, 1,0,0,'h30,RD0, 1,0,0,'h34,RD1);
    chk("in_rst flags", {28'd0, m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid}, 32'd0);
    chk("in_rst addr", mem_addr, 32'd0);
    chk("in_rst we", {31'd0, mem_wr_ena}, 32'd0);
    drive(1, 1,0,0,'h30,RD0, 0,0,0,0,RD1);
    chk("in_rst owner", 32'(dut.r_owner), 32'(IDLE));
    chk("in_rst burst", 32'(dut.r_burst), 32'd0);
    chk("in_rst rv", {30'd0, m0_rd_valid, m1_rd_valid}, 32'd0);
    drive(0, 0,0,0,0,RD0, 0,0,0,0,RD1);
    chk("post_rst rv", {30'd0, m0_rd_valid, m1_rd_valid}, 32'd0);

    // Counter runs with an unlocked owner, then clears on an idle cycle
    for (int i = 0; i < 3; i++) drive(0, 0,0,0,0,RD0, 1,0,0,'h40,RD1);
    drive(0, 0,0,0,0,RD0, 1,0,0,'h40,RD1);
    chk("burst run", 32'(dut.r_burst), 32'd3);
    drive(0, 0,0,0,0,RD0, 0,0,0,0,RD1);
    chk("idle gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk("idle addr", mem_addr, 32'd0);
    chk("idle we", {31'd0, mem_wr_ena}, 32'd0);
    drive(0, 0,0,0,0,RD0, 0,0,0,0,RD1);
    chk("idle burst", 32'(dut.r_burst), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 64; i++) begin
      ref_wr[i] = env_wr[i];
      ref_mem[i] = env_mem[i];
    end
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = (c == 0) || ($urandom_range(0, 59) == 0);
      m0_req     = ($urandom_range(0, 3) != 0);
      m0_lock    = $urandom_range(0, 1) == 1;
      m0_wr_ena  = ($urandom_range(0, 2) == 0);
      m0_addr    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      m0_wr_data = $urandom;
      m1_req     = ($urandom_range(0, 3) != 0);
      m1_lock    = $urandom_range(0, 1) == 1;
      m1_wr_ena  = ($urandom_range(0, 2) == 0);
      m1_addr    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      m1_wr_data = $urandom;
      #1;
      model_step(c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
